// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scan decoder family.
package decoder_pkg;

    localparam int unsigned MAX_SEL_W = 6;
    localparam int unsigned MAX_N     = 2 ** MAX_SEL_W;

    typedef enum logic [1:0] {
        StIdle,
        StDirect,
        StScan,
        StHold
    } dec_state_t;

    // Callers truncate the result to their own output width.
    function automatic logic [MAX_N-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        logic [MAX_N-1:0] res;
        res      = '0;
        res[idx] = 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Counts enabled cycles modulo DWELL; tick marks the last cycle of each dwell period.
module dwell_timer #(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = run && (cnt_q == CW'(DWELL - 1));

    // Count freezes whenever run is low, so a paused scan resumes mid-dwell.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with a self-running scan mode and programmable dwell.
module scan_decoder
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned DWELL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    output logic [2**SEL_W-1:0] out,
    output logic [SEL_W-1:0]    idx,
    output logic                wrap
);

    localparam int unsigned N = 2 ** SEL_W;

    function automatic logic [N-1:0] dec(input logic [SEL_W-1:0] i);
        return N'(onehot(MAX_SEL_W'(i)));
    endfunction

    dec_state_t       state_q, state_d;
    logic [N-1:0]     out_q, out_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [SEL_W-1:0] idx_inc;
    logic             wrap_q, wrap_d;
    logic             clr, run, tick;

    assign idx_inc = idx_q + SEL_W'(1);

    dwell_timer #(
        .DWELL(DWELL)
    ) u_dwell_timer (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .run (run),
        .tick(tick)
    );

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        clr     = 1'b0;
        run     = 1'b0;
        unique case (state_q)
            StIdle, StDirect: begin
                out_d   = '0;
                state_d = StIdle;
                if (en && !mode) begin
                    state_d = StDirect;
                    out_d   = dec(sel);
                    idx_d   = sel;
                end else if (en && mode) begin
                    state_d = StScan;
                    out_d   = dec(sel);
                    idx_d   = sel;
                    clr     = 1'b1;
                end
            end
            StScan: begin
                if (!en) begin
                    state_d = StHold;
                    out_d   = '0;
                end else if (!mode) begin
                    state_d = StDirect;
                    out_d   = dec(sel);
                    idx_d   = sel;
                end else begin
                    run = 1'b1;
                    if (tick) begin
                        idx_d  = idx_inc;
                        out_d  = dec(idx_inc);
                        wrap_d = &idx_q;
                    end
                end
            end
            StHold: begin
                out_d = '0;
                if (en && mode) begin
                    // Resume frozen position; the timer keeps its frozen count.
                    state_d = StScan;
                    out_d   = dec(idx_q);
                end else if (!mode && !en) begin
                    state_d = StIdle;
                end else if (!mode) begin
                    state_d = StDirect;
                    out_d   = dec(sel);
                    idx_d   = sel;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            out_q   <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
        end
    end

    assign out  = out_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: SEL_W=3/DWELL=4 instance plus a SEL_W=2/DWELL=1 instance.
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, mode;
    logic [2:0] sel;
    logic [7:0] out;
    logic [2:0] idx;
    logic       wrap;
    logic       en1, mode1;
    logic [1:0] sel1;
    logic [3:0] out1;
    logic [1:0] idx1;
    logic       wrap1;

    typedef struct {
        logic [7:0] out;
        logic [2:0] idx;
        logic       wrap;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    scan_decoder #(.SEL_W(3), .DWELL(4)) u_dut (
        .clk (clk), .rst (rst), .en (en), .mode (mode), .sel (sel),
        .out (out), .idx (idx), .wrap (wrap)
    );

    scan_decoder #(.SEL_W(2), .DWELL(1)) u_dut1 (
        .clk (clk), .rst (rst), .en (en1), .mode (mode1), .sel (sel1),
        .out (out1), .idx (idx1), .wrap (wrap1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic on, input logic w);
        exp_t e;
        logic [7:0] o;
        o = 8'h01 << i;
        e.out  = on ? o : 8'h00;
        e.idx  = 3'(i);
        e.wrap = w;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0;
        en1 = 1'b0; mode1 = 1'b0; sel1 = '0;
        push(0, 1'b0, 1'b0);
        tick();
        tick();
        e = sb.pop_front();
        vectors++;
        if (out !== e.out || idx !== e.idx || wrap !== e.wrap) begin
            miscompares++;
            $display("FAIL reset: out=%h idx=%0d wrap=%b, required out=%h idx=%0d wrap=%b",
                     out, idx, wrap, e.out, e.idx, e.wrap);
        end
        vectors++;
        if (out1 !== e.out[3:0] || idx1 !== e.idx[1:0] || wrap1 !== e.wrap) begin
            miscompares++;
            $display("FAIL reset1: out=%h idx=%0d wrap=%b, required out=0 idx=0 wrap=0",
                     out1, idx1, wrap1);
        end
        rst = 1'b0;
    endtask

    task automatic test_direct();
        exp_t e;
        en = 1'b1; mode = 1'b0;
        for (int s = 0; s < 9; s++) begin
            if (s == 8) begin
                en = 1'b0;
                push(7, 1'b0, 1'b0);
            end else begin
                sel = 3'(s);
                push(s, 1'b1, 1'b0);
            end
            tick();
            e = sb.pop_front();
            vectors++;
            if (out !== e.out || idx !== e.idx || wrap !== e.wrap) begin
                miscompares++;
                $display("FAIL direct s=%0d: out=%h idx=%0d wrap=%b, required out=%h idx=%0d wrap=%b",
                         s, out, idx, wrap, e.out, e.idx, e.wrap);
            end
        end
    endtask

    // Full period from sel=5 plus a few cycles past it; sel wiggles to prove it is ignored.
    task automatic test_scan();
        exp_t e;
        int   i;
        en = 1'b1; mode = 1'b1; sel = 3'd5;
        for (int c = 0; c < 38; c++) begin
            if (c > 0) sel = 3'(c * 3);
            if (c == 36) en = 1'b0;
            if (c == 37) mode = 1'b0;
            i = (c < 36) ? (5 + c / 4) % 8 : 5;
            push(i, c < 36, c > 0 && c < 36 && c % 4 == 0 && i == 0);
            tick();
            e = sb.pop_front();
            vectors++;
            if (out !== e.out || idx !== e.idx || wrap !== e.wrap) begin
                miscompares++;
                $display("FAIL scan c=%0d: out=%h idx=%0d wrap=%b, required out=%h idx=%0d wrap=%b",
                         c, out, idx, wrap, e.out, e.idx, e.wrap);
            end
        end
    endtask

    task automatic test_pause();
        exp_t e;
        sel = 3'd3; en = 1'b1; mode = 1'b1;
        for (int k = 0; k < 11; k++) begin
            en = !(k >= 3 && k <= 7);
            if (k == 10) push(4, 1'b1, 1'b0);
            else         push(3, en, 1'b0);
            tick();
            e = sb.pop_front();
            vectors++;
            if (out !== e.out || idx !== e.idx || wrap !== e.wrap) begin
                miscompares++;
                $display("FAIL pause k=%0d: out=%h idx=%0d wrap=%b, required out=%h idx=%0d wrap=%b",
                         k, out, idx, wrap, e.out, e.idx, e.wrap);
            end
        end
    endtask

    // Continues from idx=4 dwell=0; drops en on the idx=7 step edge.
    task automatic test_collision();
        exp_t e;
        for (int k = 1; k < 22; k++) begin
            en = 1'b1; mode = 1'b1;
            if (k <= 15)      push(4 + k / 4, 1'b1, 1'b0);
            else if (k <= 17) begin en = 1'b0; push(7, 1'b0, 1'b0); end
            else if (k == 18) push(7, 1'b1, 1'b0);
            else if (k == 19) push(0, 1'b1, 1'b1);
            else if (k == 20) begin en = 1'b0; push(0, 1'b0, 1'b0); end
            else              begin en = 1'b0; mode = 1'b0; push(0, 1'b0, 1'b0); end
            tick();
            e = sb.pop_front();
            vectors++;
            if (out !== e.out || idx !== e.idx || wrap !== e.wrap) begin
                miscompares++;
                $display("FAIL collision k=%0d: out=%h idx=%0d wrap=%b, required out=%h idx=%0d wrap=%b",
                         k, out, idx, wrap, e.out, e.idx, e.wrap);
            end
        end
    endtask

    // Reset mid-scan, re-entry from sel, then a mode change on a step edge.
    task automatic test_reset_mid_and_mode();
        exp_t e;
        en = 1'b1; mode = 1'b1; sel = 3'd6;
        for (int k = 0; k < 9; k++) begin
            rst = (k == 2);
            if (k == 3) sel = 3'd2;
            if (k == 7) begin mode = 1'b0; sel = 3'd1; end
            if (k == 8) en = 1'b0;
            if (k < 2)       push(6, 1'b1, 1'b0);
            else if (k == 2) push(0, 1'b0, 1'b0);
            else if (k < 7)  push(2, 1'b1, 1'b0);
            else             push(1, k == 7, 1'b0);
            tick();
            e = sb.pop_front();
            vectors++;
            if (out !== e.out || idx !== e.idx || wrap !== e.wrap) begin
                miscompares++;
                $display("FAIL reset_mid k=%0d: out=%h idx=%0d wrap=%b, required out=%h idx=%0d wrap=%b",
                         k, out, idx, wrap, e.out, e.idx, e.wrap);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_dwell1();
        exp_t e;
        en1 = 1'b1; mode1 = 1'b1; sel1 = 2'd0;
        for (int k = 0; k < 12; k++) begin
            push(k % 4, 1'b1, k > 0 && k % 4 == 0);
            tick();
            e = sb.pop_front();
            vectors++;
            if (out1 !== e.out[3:0] || idx1 !== e.idx[1:0] || wrap1 !== e.wrap) begin
                miscompares++;
                $display("FAIL dwell1 k=%0d: out=%h idx=%0d wrap=%b, required out=%h idx=%0d wrap=%b",
                         k, out1, idx1, wrap1, e.out[3:0], e.idx[1:0], e.wrap);
            end
        end
        en1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan();
        test_pause();
        test_collision();
        test_reset_mid_and_mode();
        test_dwell1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
